seg_display_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 36 +++
 rtl/bin2bcd_seq.sv | 46 ++++
 rtl/seg_display_ctrl.sv | 150 +++++++++++++++
 tb/tb_seg_display_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types, display codes and font for the 4-digit 7-segment controller.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   localparam int BIN_W = 14;
   localparam int BCD_W = 16;
   localparam int unsigned MAX_VALUE = 9999;

   localparam logic [3:0] BLANK = 4'hF;
   localparam logic [3:0] DASH  = 4'hE;

   function automatic logic [6:0] font(input logic [3:0] code);
      logic [6:0] s;
      case (code)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110000;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         DASH:    s = 7'b0000001;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one shift per clock.
module bin2bcd_seq
   import seg_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   logic [BIN_W-1:0] sh_bin;
   logic [BCD_W-1:0] sh_bcd;
   logic [BCD_W-1:0] adj;
   logic [3:0]       cnt;

   always_comb begin
      adj = sh_bcd;
      for (int i = 0; i < 4; i++) begin
         if (sh_bcd[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = sh_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_bin <= '0;
         sh_bcd <= '0;
         cnt    <= '0;
      end else if (start) begin
         sh_bin <= bin;
         sh_bcd <= '0;
         cnt    <= 4'(BIN_W);
      end else if (cnt != 4'd0) begin
         {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
         cnt <= cnt - 4'd1;
      end
   end

   // High during the cycle whose closing edge performs the final shift.
   assign done = (cnt == 4'd1);
   assign bcd  = sh_bcd;

endmodule

// File: rtl/seg_display_ctrl.sv
// Value loader, BCD conversion, blanking and digit scanner
// for a 4-digit multiplexed 7-segment display.
module seg_display_ctrl
   import seg_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int REFRESH_HZ = 60
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [13:0] in_value,
   input  logic [3:0]  in_dp,
   input  logic        in_blank_lz,
   output logic        overflow,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an
);

   localparam int SCAN_DIV = CLK_HZ / (REFRESH_HZ * 4);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   state_t state;
   state_t state_nx;

   logic             start;
   logic             commit;
   logic             done;
   logic [BCD_W-1:0] bcd;

   logic       cap_blz;
   logic       cap_ovf;
   logic [3:0] cap_dp;

   logic [3:0][3:0] nd;
   logic [3:0][3:0] dig;
   logic [3:0]      dp_r;
   logic            ovf_r;

   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       slot;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (in_valid) state_nx = CONVERT;
         CONVERT: if (done) state_nx = COMMIT;
         COMMIT:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      commit   = 1'b0;
      unique case (state)
         IDLE:    in_ready = 1'b1;
         COMMIT:  commit   = 1'b1;
         default: ;
      endcase
   end

   assign start = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_dp  <= '0;
         cap_blz <= 1'b0;
         cap_ovf <= 1'b0;
      end else if (start) begin
         cap_dp  <= in_dp;
         cap_blz <= in_blank_lz;
         cap_ovf <= (in_value > 14'(MAX_VALUE));
      end
   end

   bin2bcd_seq u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (in_value),
      .done  (done),
      .bcd   (bcd)
   );

   // nd[0] is thousands; a zero digit blanks only if all higher ones are zero.
   always_comb begin
      nd[0] = bcd[15:12];
      nd[1] = bcd[11:8];
      nd[2] = bcd[7:4];
      nd[3] = bcd[3:0];
      if (cap_blz && bcd[15:12] == 4'd0) begin
         nd[0] = BLANK;
      end
      if (cap_blz && bcd[15:8] == 8'd0) begin
         nd[1] = BLANK;
      end
      if (cap_blz && bcd[15:4] == 12'd0) begin
         nd[2] = BLANK;
      end
      if (cap_ovf) begin
         nd = {4{DASH}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dig   <= {4{BLANK}};
         dp_r  <= '0;
         ovf_r <= 1'b0;
      end else if (commit) begin
         dig   <= nd;
         dp_r  <= cap_ovf ? 4'd0 : cap_dp;
         ovf_r <= cap_ovf;
      end
   end

   assign overflow = ovf_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         slot     <= 2'd0;
         an       <= 4'b0001;
         seg      <= 7'b0000000;
         dp       <= 1'b0;
      end else begin
         if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            slot     <= slot + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         an  <= 4'b0001 << slot;
         seg <= font(dig[slot]);
         dp  <= dp_r[2'd3 - slot];
      end
   end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Randomized and directed bench for seg_display_ctrl
// with an arithmetic reference model of the display.
module tb_seg_display_ctrl;

   localparam int SCAN_DIV = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [13:0] in_value = '0;
   logic [3:0]  in_dp = '0;
   logic        in_blank_lz = 1'b0;
   logic        overflow;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;

   seg_display_ctrl #(
      .CLK_HZ     (4800),
      .REFRESH_HZ (60)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_value    (in_value),
      .in_dp       (in_dp),
      .in_blank_lz (in_blank_lz),
      .overflow    (overflow),
      .seg         (seg),
      .dp          (dp),
      .an          (an)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int n_prt  = 0;

   logic [6:0] FONT [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011
   };
   int P10 [4] = '{1000, 100, 10, 1};

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         if (n_prt < 40) begin
            n_prt++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     nm, act, exp, $time);
         end
      end
   endtask

   // Reference model: committed value and its display attributes.
   bit         armed = 0;
   int         ecnt  = 0;
   int         mbusy = 0;
   bit         mhas  = 0;
   int         mval  = 0;
   logic [3:0] mdp   = '0;
   bit         mblz  = 0;
   int         pv    = 0;
   logic [3:0] pd    = '0;
   bit         pb    = 0;

   function automatic logic [6:0] mseg(int sl);
      if (!mhas) return 7'b0000000;
      if (mval > 9999) return 7'b0000001;
      if (mblz && sl < 3 && mval < P10[sl]) return 7'b0000000;
      return FONT[(mval / P10[sl]) % 10];
   endfunction

   function automatic logic mdpf(int sl);
      if (!mhas || mval > 9999) return 1'b0;
      return mdp[3 - sl];
   endfunction

   always begin : model
      logic [6:0] xs;
      logic       xd;
      logic [3:0] xa;
      int         sl;
      @(posedge clk);
      if (rst) begin
         xa = 4'b0001; xs = '0; xd = 1'b0;
         armed = 1; ecnt = 0; mbusy = 0; mhas = 0;
      end else begin
         sl = (ecnt / SCAN_DIV) % 4;
         xa = 4'b0001 << sl;
         xs = mseg(sl);
         xd = mdpf(sl);
         ecnt++;
         if (mbusy > 0) begin
            mbusy--;
            if (mbusy == 0) begin
               mhas = 1; mval = pv; mdp = pd; mblz = pb;
            end
         end else if (in_valid) begin
            pv = int'(in_value); pd = in_dp; pb = in_blank_lz;
            mbusy = 15;
         end
      end
      #1;
      if (armed) begin
         chk("seg", int'(seg), int'(xs));
         chk("dp", int'(dp), int'(xd));
         chk("an", int'(an), int'(xa));
         chk("in_ready", int'(in_ready), int'(mbusy == 0));
         chk("overflow", int'(overflow),
             int'(mhas && mval > 9999));
      end
   end

   int         lowc;
   logic [6:0] cap_seg [4];
   logic       cap_dp  [4];

   task automatic load(input int v, input logic [3:0] d, input logic b);
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("load_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_value = 14'(v);
      in_dp = d;
      in_blank_lz = b;
      @(negedge clk);
      in_valid = 1'b0;
      lowc = 1;
      while (!in_ready && lowc < 40) begin
         @(negedge clk);
         lowc++;
      end
      lowc--;
      chk("busy_cycles", lowc, 15);
   endtask

   task automatic sweep();
      for (int k = 0; k < 4; k++) begin
         cap_seg[k] = 7'h7f;
         cap_dp[k] = 1'b1;
      end
      for (int n = 0; n < 85; n++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (an == (4'b0001 << k)) begin
               cap_seg[k] = seg;
               cap_dp[k] = dp;
            end
         end
      end
   endtask

   task automatic chk_slots(input string nm,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dps);
      sweep();
      chk({nm, "_s0"}, int'(cap_seg[0]), int'(s0));
      chk({nm, "_s1"}, int'(cap_seg[1]), int'(s1));
      chk({nm, "_s2"}, int'(cap_seg[2]), int'(s2));
      chk({nm, "_s3"}, int'(cap_seg[3]), int'(s3));
      chk({nm, "_dp"},
          int'({cap_dp[0], cap_dp[1], cap_dp[2], cap_dp[3]}),
          int'(dps));
   endtask

   initial begin
      int gap;
      int r;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_an", int'(an), 4'b0001);
      chk("rst_seg", int'(seg), 0);
      chk("rst_ready", int'(in_ready), 1);
      repeat (21) @(negedge clk);
      chk("scan_an1", int'(an), 4'b0010);
      repeat (20) @(negedge clk);
      chk("scan_an2", int'(an), 4'b0100);
      repeat (20) @(negedge clk);
      chk("scan_an3", int'(an), 4'b1000);
      chk("idle_seg", int'(seg), 0);

      load(1234, 4'b0010, 1'b0);
      chk_slots("v1234", 7'b0110000, 7'b1101101,
                7'b1111001, 7'b0110011, 4'b0010);
      chk("ovf1234", int'(overflow), 0);

      load(7, 4'b0000, 1'b1);
      chk_slots("v7", 7'b0, 7'b0, 7'b0, 7'b1110000, 4'b0000);

      load(0, 4'b0000, 1'b1);
      chk_slots("v0", 7'b0, 7'b0, 7'b0, 7'b1111110, 4'b0000);

      load(12000, 4'b1111, 1'b0);
      chk_slots("v12000", 7'b0000001, 7'b0000001,
                7'b0000001, 7'b0000001, 4'b0000);
      chk("ovf12000", int'(overflow), 1);

      load(9999, 4'b0000, 1'b0);
      chk_slots("v9999", 7'b1111011, 7'b1111011,
                7'b1111011, 7'b1111011, 4'b0000);
      chk("ovf9999", int'(overflow), 0);

      // Held in_valid: second value must be taken 16 cycles later.
      in_valid = 1'b1;
      in_value = 14'd5;
      in_blank_lz = 1'b1;
      in_dp = 4'b0000;
      @(negedge clk);
      in_value = 14'd6;
      gap = 1;
      while (!in_ready && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      chk("b2b_gap", gap, 16);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) @(negedge clk);
      chk_slots("v6", 7'b0, 7'b0, 7'b0, 7'b1011111, 4'b0000);

      // Reset five cycles into a conversion.
      in_valid = 1'b1;
      in_value = 14'd4321;
      in_blank_lz = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", int'(in_ready), 1);
      chk("abort_ovf", int'(overflow), 0);
      repeat (20) @(negedge clk);
      chk_slots("abort", 7'b0, 7'b0, 7'b0, 7'b0, 4'b0000);

      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         in_valid = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 3);
         case (r)
            0:       in_value = 14'($urandom_range(0, 9));
            1:       in_value = 14'($urandom_range(0, 99));
            2:       in_value = 14'($urandom_range(0, 9999));
            default: in_value = 14'($urandom_range(0, 16383));
         endcase
         in_dp = 4'($urandom_range(0, 15));
         in_blank_lz = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
